// File: rtl/buf_pkg.sv
// rtl/buf_pkg.sv - shared types, default widths and credit helper for the buffer reader
package buf_pkg;

   localparam int C_BUF_ADDR_WIDTH = 10;
   localparam int C_BUF_DATA_WIDTH = 8;
   localparam int C_SKID_DEPTH     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } buf_rd_state_t;

   // Words that will occupy the skid after this edge must stay below its depth,
   // so a read issued now always finds a free slot when its data lands.
   function automatic logic credit_ok(input logic in_flight,
                                      input logic [1:0] skid_count,
                                      input logic pop);
      logic [1:0] occ;
      occ = skid_count + {1'b0, in_flight} - {1'b0, pop};
      return occ < 2'(C_SKID_DEPTH);
   endfunction

endpackage

// File: rtl/buf_rd_skid.sv
// rtl/buf_rd_skid.sv - 2-entry register FIFO with fall-through when empty
module buf_rd_skid
   import buf_pkg::*;
#(
   parameter int G_DATA_WIDTH = C_BUF_DATA_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    push_i,
   input  logic [G_DATA_WIDTH-1:0] push_data_i,
   input  logic                    pop_i,
   output logic [G_DATA_WIDTH-1:0] data_o,
   output logic                    valid_o,
   output logic [1:0]              count_o
);

   logic [G_DATA_WIDTH-1:0] entry0;
   logic [G_DATA_WIDTH-1:0] entry1;
   logic [1:0]              count;

   // An empty FIFO presents the word arriving this cycle directly on its head.
   assign data_o  = (count == 2'd0) ? push_data_i : entry0;
   assign valid_o = (count != 2'd0) || push_i;
   assign count_o = count;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         assert (!(count == 2'd2 && push_i && !pop_i));
         assert (!(pop_i && !valid_o));
         case (count)
            2'd0: begin
               if (push_i && !pop_i) begin
                  entry0 <= push_data_i;
                  count  <= 2'd1;
               end
            end
            2'd1: begin
               case ({push_i, pop_i})
                  2'b11: entry0 <= push_data_i;
                  2'b10: begin
                     entry1 <= push_data_i;
                     count  <= 2'd2;
                  end
                  2'b01: count <= 2'd0;
                  default: ;
               endcase
            end
            2'd2: begin
               if (pop_i) begin
                  entry0 <= entry1;
                  count  <= 2'd1;
                  if (push_i) begin
                     entry1 <= push_data_i;
                     count  <= 2'd2;
                  end
               end
            end
            default: count <= 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/buf_reader.sv
// rtl/buf_reader.sv - streams a run of words out of a 1-cycle-latency buffer read port
module buf_reader
   import buf_pkg::*;
#(
   parameter int G_BUF_ADDR_WIDTH = C_BUF_ADDR_WIDTH,
   parameter int G_BUF_DATA_WIDTH = C_BUF_DATA_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [G_BUF_ADDR_WIDTH-1:0] base_addr_i,
   input  logic [G_BUF_ADDR_WIDTH:0]   len_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [G_BUF_ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [G_BUF_DATA_WIDTH-1:0] rd_data_i,
   output logic [G_BUF_DATA_WIDTH-1:0] m_data_o,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic                        m_last_o
);

   localparam int                    AW       = G_BUF_ADDR_WIDTH;
   localparam logic [AW-1:0]         ADDR_ONE = AW'(1);
   localparam logic [AW:0]           CNT_ONE  = (AW + 1)'(1);

   buf_rd_state_t state;
   buf_rd_state_t state_nxt;

   logic [AW:0] issue_cnt;
   logic [AW:0] beat_cnt;
   logic        in_flight;
   logic        done_q;
   logic [1:0]  skid_count;

   logic        pop;
   logic        issue;
   logic        start_run;
   logic        start_zero;
   logic        last_pop;

   assign pop = m_valid_o && m_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_run) state_nxt = RUN;
         RUN:     if (issue && issue_cnt == CNT_ONE) state_nxt = FLUSH;
         FLUSH:   if (last_pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = (state != IDLE);
      start_run  = (state == IDLE) && start_i && (len_i != '0);
      start_zero = (state == IDLE) && start_i && (len_i == '0);
      issue      = (state == RUN) && (issue_cnt != '0) &&
                   credit_ok(in_flight, skid_count, pop);
      last_pop   = (state == FLUSH) && pop && (beat_cnt == CNT_ONE);
   end

   // Address, counters and the one-deep read pipeline tracker.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_addr_o <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         in_flight <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         in_flight <= issue;
         done_q    <= start_zero || last_pop;
         if (start_run) begin
            rd_addr_o <= base_addr_i;
            issue_cnt <= len_i;
         end else if (issue) begin
            rd_addr_o <= rd_addr_o + ADDR_ONE;
            issue_cnt <= issue_cnt - CNT_ONE;
         end
         if (start_run) begin
            beat_cnt <= len_i;
         end else if (pop) begin
            beat_cnt <= beat_cnt - CNT_ONE;
         end
      end
   end

   assign done_o   = done_q;
   assign m_last_o = m_valid_o && (beat_cnt == CNT_ONE);

   buf_rd_skid #(
      .G_DATA_WIDTH(G_BUF_DATA_WIDTH)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (in_flight),
      .push_data_i (rd_data_i),
      .pop_i       (pop),
      .data_o      (m_data_o),
      .valid_o     (m_valid_o),
      .count_o     (skid_count)
   );

endmodule

// File: tb/tb_buf_reader.sv
// tb/tb_buf_reader.sv - scoreboard bench for buf_reader with a behavioural buffer model
module tb_buf_reader;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   logic [DW-1:0] mem [DEPTH];
   logic [DW:0]   exp_q [$];

   int checks   = 0;
   int errors   = 0;
   int beats    = 0;
   int done_cnt = 0;
   int pat [4]  = '{1, 0, 0, 1};

   bit            stall_q = 0;
   logic [DW-1:0] stall_data;
   logic          stall_last;

   buf_reader #(
      .G_BUF_ADDR_WIDTH(AW),
      .G_BUF_DATA_WIDTH(DW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .base_addr_i (base_addr),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .rd_addr_o   (rd_addr),
      .rd_data_i   (rd_data),
      .m_data_o    (m_data),
      .m_valid_o   (m_valid),
      .m_ready_i   (m_ready),
      .m_last_o    (m_last)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   // Scoreboard consumer and hold-stability monitor.
   always @(negedge clk) begin
      logic [DW:0] e;
      if (rst_n && stall_q) begin
         checks++;
         if (!m_valid || m_data !== stall_data || m_last !== stall_last) begin
            errors++;
            $display("FAIL hold_stable: got v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                     m_valid, m_data, m_last, stall_data, stall_last);
         end
      end
      stall_q    = rst_n && m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (rst_n && m_valid && m_ready) begin
         checks++;
         beats++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got d=%0h required no beat", m_data);
         end else begin
            e = exp_q.pop_front();
            if (m_data !== e[DW-1:0] || m_last !== e[DW]) begin
               errors++;
               $display("FAIL beat_data: got d=%0h l=%0b required d=%0h l=%0b",
                        m_data, m_last, e[DW-1:0], e[DW]);
            end
         end
      end
      if (rst_n && done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int b, input int n);
      start     = 1'b1;
      base_addr = AW'(b);
      len       = (AW + 1)'(n);
      for (int k = 0; k < n; k++)
         exp_q.push_back({(k == n - 1), mem[(b + k) % DEPTH]});
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit seen);
      cycles = 0;
      seen   = 0;
      while (cycles < budget && !seen) begin
         step();
         cycles++;
         if (done) seen = 1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
      repeat (3) step();
      checks++;
      if ({busy, done, m_valid, m_last} !== 4'b0 || rd_addr !== '0) begin
         errors++;
         $display("FAIL reset_state: got b=%0b d=%0b v=%0b l=%0b a=%0d required all 0",
                  busy, done, m_valid, m_last, rd_addr);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int  cyc;
      bit  seen;
      m_ready = 1'b1;
      start_run(5, 4);
      checks++;
      if (busy !== 1'b1 || rd_addr !== AW'(5) || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_cycle: got b=%0b a=%0d v=%0b required b=1 a=5 v=0",
                  busy, rd_addr, m_valid);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (m_valid !== 1'b1 || m_last !== (k == 3) || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat%0d: got v=%0b l=%0b d=%0b required v=1 l=%0b d=0",
                     k, m_valid, m_last, done, (k == 3));
         end
      end
      wait_done(10, cyc, seen);
      checks++;
      if (!seen || cyc != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got seen=%0b cyc=%0d busy=%0b required seen=1 cyc=1 busy=0",
                  seen, cyc, busy);
      end
   endtask

   task automatic test_wrap();
      int  cyc;
      bit  seen;
      int  addrs [4] = '{1022, 1023, 0, 1};
      m_ready = 1'b1;
      start_run(1022, 4);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rd_addr !== AW'(addrs[k])) begin
            errors++;
            $display("FAIL wrap_addr%0d: got %0d required %0d", k, rd_addr, addrs[k]);
         end
         step();
      end
      wait_done(10, cyc, seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_done: got seen=%0b left=%0d required seen=1 left=0",
                  seen, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int b0;
      bit seen;
      b0   = beats;
      seen = 0;
      m_ready = 1'b1;
      start_run(300, 8);
      for (int i = 0; i < 200 && !seen; i++) begin
         m_ready = (pat[i % 4] != 0);
         step();
         if (done) seen = 1;
      end
      m_ready = 1'b1;
      checks++;
      if (!seen || exp_q.size() != 0 || beats - b0 != 8) begin
         errors++;
         $display("FAIL backpressure: got seen=%0b left=%0d beats=%0d required seen=1 left=0 beats=8",
                  seen, exp_q.size(), beats - b0);
      end
   endtask

   task automatic test_zero_len();
      int b0;
      b0 = beats;
      m_ready = 1'b1;
      start_run(77, 0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: got d=%0b b=%0b v=%0b required d=1 b=0 v=0",
                  done, busy, m_valid);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet%0d: got d=%0b b=%0b v=%0b required 0 0 0",
                     k, done, busy, m_valid);
         end
      end
      checks++;
      if (beats != b0) begin
         errors++;
         $display("FAIL zero_beats: got %0d required 0", beats - b0);
      end
   endtask

   task automatic test_restart_ignored();
      int d0, b0, cyc;
      bit seen;
      d0 = done_cnt;
      b0 = beats;
      m_ready = 1'b1;
      start_run(200, 6);
      step();
      start = 1'b1; base_addr = AW'(300); len = (AW + 1)'(3);
      step();
      step();
      start = 1'b0;
      wait_done(20, cyc, seen);
      repeat (5) step();
      checks++;
      if (!seen || exp_q.size() != 0 || beats - b0 != 6 || done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_ignored: got seen=%0b left=%0d beats=%0d dones=%0d busy=%0b required 1 0 6 1 0",
                  seen, exp_q.size(), beats - b0, done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int  b0, d0, cyc;
      bit  seen;
      m_ready = 1'b1;
      b0 = beats;
      start_run(50, 10);
      for (int i = 0; i < 50 && beats < b0 + 3; i++) step();
      checks++;
      if (beats < b0 + 3) begin
         errors++;
         $display("FAIL midrst_reach: got %0d beats required 3", beats - b0);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({busy, done, m_valid, m_last} !== 4'b0 || rd_addr !== '0) begin
         errors++;
         $display("FAIL midrst_state: got b=%0b d=%0b v=%0b l=%0b a=%0d required all 0",
                  busy, done, m_valid, m_last, rd_addr);
      end
      rst_n = 1'b1;
      exp_q.delete();
      d0 = done_cnt;
      repeat (15) step();
      checks++;
      if (done_cnt != d0 || m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet: got dones=%0d v=%0b b=%0b required 0 0 0",
                  done_cnt - d0, m_valid, busy);
      end
      start_run(1000, 5);
      wait_done(20, cyc, seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midrst_fresh: got seen=%0b left=%0d required seen=1 left=0",
                  seen, exp_q.size());
      end
   endtask

   task automatic test_full_len();
      int cyc;
      bit seen;
      m_ready = 1'b1;
      start_run(7, DEPTH);
      wait_done(DEPTH + 50, cyc, seen);
      checks++;
      if (!seen || cyc != DEPTH + 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_len: got seen=%0b cyc=%0d left=%0d required seen=1 cyc=%0d left=0",
                  seen, cyc, exp_q.size(), DEPTH + 1);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37) + (i >> 5) + 11);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_restart_ignored();
      test_reset_mid_run();
      test_full_len();
      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
